traffic_light_ctrl: RTL and testbench
=====================================

// Module: traffic_light_ctrl
// PURPOSE
//  Lights controller for the Academic Ave (A) / Bravo Blvd (B) crossing. Consumes mode bit i_M from
//  the parade mode FSM (same clock domain) plus raw traffic sensors TA/TB. Drives both light heads.
//  Guarantees a minimum green and a fixed yellow per direction. Parade mode (i_M=1) forces and holds B green.
// PARAMETERS
//  MIN_GREEN    4  green length in clock cycles before a change is allowed (>=1)
//  YELLOW_LEN   2  yellow length in clock cycles, exact (>=1)
//  CNT_W        $clog2(max(MIN_GREEN,YELLOW_LEN))+1  timer width (localparam, not overridable)
// PORTS
//  i_clk     in   1  clock
//  i_rstn    in   1  reset, asynchronous, active-low
//  i_M       in   1  parade mode from mode FSM; synchronous, used directly
//  i_TA      in   1  traffic present on A; asynchronous, 2-FF synchronised internally
//  i_TB      in   1  traffic present on B; asynchronous, 2-FF synchronised internally
//  o_LA      out  2  A light: 2'b00 green, 2'b01 yellow, 2'b10 red (2'b11 never driven)
//  o_LB      out  2  B light, same encoding
//  o_parade  out  1  1 while in S_BG with i_M=1 (parade hold active); registered
// BEHAVIOUR
//  States (2-bit): S_AG (A green, B red), S_AY (A yellow, B red), S_BG (A red, B green), S_BY (A red, B yellow).
//  Reset: state=S_AG, timer=0, sync flops=0, o_LA=00, o_LB=10, o_parade=0. Async assert, applies at once.
//  Outputs: o_LA/o_LB are Moore decode of the state register. No input-to-output combinational path.
//  Sensors: tA/tB = i_TA/i_TB after 2 flops. Sensor edge reaches FSM decision 2 cycles late.
//  Timer: cleared to 0 on every state change. Otherwise increments each cycle, saturating at limit-1.
//    limit = MIN_GREEN in S_AG/S_BG, YELLOW_LEN in S_AY/S_BY.
//  Transitions (evaluated each cycle; done = timer==limit-1):
//   S_AG -> S_AY  when done && (!tA || i_M)      else hold
//   S_AY -> S_BG  when done (unconditional)      else hold
//   S_BG -> S_BY  when done && !tB && !i_M       else hold (i_M=1 holds B green indefinitely)
//   S_BY -> S_AG  when done (unconditional)      else hold
//  Timing: green lasts >= MIN_GREEN cycles. Yellow lasts exactly YELLOW_LEN cycles. Never red/red, never green/green.
//  i_M edges:
//   Rise in S_AY or S_BG: no extra effect.
//   Rise in S_BY: yellow completes, then S_AG runs MIN_GREEN and exits immediately (i_M overrides tA).
//   Fall in S_BG: normal tB rule resumes next cycle.
//  o_parade <= (next_state==S_BG) && i_M. It deasserts the cycle after the state leaves S_BG or i_M falls.
//  Simultaneous tA=1 and i_M=1 in S_AG: i_M wins once done.
//  Reset mid-operation (any state, any timer value): immediate return to reset values. No yellow is inserted.
//  Illegal state encodings: none exist, since the 2-bit state is fully used.
// STRUCTURE
//  Shared header traffic_defs.vh: light codes LIGHT_GREEN/YELLOW/RED and state codes S_AG/S_AY/S_BG/S_BY,
//  also used by the mode FSM bench and the top level.
//  One sub-module: sync_2ff (1-bit, async active-low reset to 0), instantiated twice for TA/TB.
//  Top of system: parade mode FSM o_M -> i_M here.
// TESTING (MIN_GREEN=4, YELLOW_LEN=2 unless stated)
//  1 Reset: assert i_rstn=0 mid-clock -> o_LA=00, o_LB=10, o_parade=0 before the next edge. Hold TA=1 -> stays S_AG forever.
//  2 Normal cycle: TA=0, TB=0, M=0 -> AG 4 cycles, AY 2, BG 4, BY 2, repeating (period 12). Check exact edges.
//  3 Sensor latency: in S_AG past MIN_GREEN with TA=1, drop TA at edge n -> o_LA=01 first seen after edge n+3.
//  4 Parade: M=1 in S_AG -> AY 2 cycles, then BG held 50 cycles with TB=0, o_parade=1.
//    M=0 -> BY after 1 cycle, o_parade=0.
//  5 M rise during S_BY with TA=1 -> BY completes, AG exactly 4 cycles, then AY.
//  6 Reset mid-S_AY (timer=1) -> S_AG, timer 0. Next AG lasts full MIN_GREEN. Repeat with MIN_GREEN=1, YELLOW_LEN=1.

Source files
------------

// File: rtl/traffic_light_ctrl_pkg.sv
// Shared light/state codes for the A/B crossing controller and its benches.
// Light heads are a Moore decode of the 2-bit state.
package traffic_light_ctrl_pkg;

  localparam logic [1:0] LIGHT_GREEN  = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_RED    = 2'b10;

  typedef enum logic [1:0] {
    S_AG = 2'b00,
    S_AY = 2'b01,
    S_BG = 2'b10,
    S_BY = 2'b11
  } state_e;

  typedef struct packed {
    logic [1:0] la;
    logic [1:0] lb;
  } lights_t;

  function automatic lights_t decode_lights(input state_e s);
    lights_t l;
    l = '{la: LIGHT_RED, lb: LIGHT_RED};
    case (s)
      S_AG: l = '{la: LIGHT_GREEN,  lb: LIGHT_RED};
      S_AY: l = '{la: LIGHT_YELLOW, lb: LIGHT_RED};
      S_BG: l = '{la: LIGHT_RED,    lb: LIGHT_GREEN};
      S_BY: l = '{la: LIGHT_RED,    lb: LIGHT_YELLOW};
      default: l = '{la: LIGHT_RED, lb: LIGHT_RED};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_sync_2ff.sv
// Two-flop synchroniser for one asynchronous sensor bit; both flops reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// A/B crossing lights: minimum green, exact yellow, parade mode holds B green.
// Sensors are synchronised; parade bit comes from the same clock domain.
module traffic_light_ctrl
  import traffic_light_ctrl_pkg::*;
#(
  parameter int MIN_GREEN  = 4,
  parameter int YELLOW_LEN = 2
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_M,
  input  logic       i_TA,
  input  logic       i_TB,
  output logic [1:0] o_LA,
  output logic [1:0] o_LB,
  output logic       o_parade
);

  localparam int MAX_LEN = (MIN_GREEN > YELLOW_LEN) ? MIN_GREEN : YELLOW_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;

  logic             ta, tb;
  state_e           state, next_state;
  logic [CNT_W-1:0] timer, limit_m1;
  logic             done;
  lights_t          lights;

  sync_2ff u_sync_ta (.clk(i_clk), .rstn(i_rstn), .d(i_TA), .q(ta));
  sync_2ff u_sync_tb (.clk(i_clk), .rstn(i_rstn), .d(i_TB), .q(tb));

  always_comb begin
    limit_m1 = CNT_W'(YELLOW_LEN - 1);
    if (state == S_AG || state == S_BG) limit_m1 = CNT_W'(MIN_GREEN - 1);
  end

  assign done = (timer == limit_m1);

  // Parade overrides A traffic so B gets the road as soon as green minimum is met.
  always_comb begin
    next_state = state;
    case (state)
      S_AG: if (done && (!ta || i_M))  next_state = S_AY;
      S_AY: if (done)                  next_state = S_BG;
      S_BG: if (done && !tb && !i_M)   next_state = S_BY;
      S_BY: if (done)                  next_state = S_AG;
      default:                         next_state = S_AG;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= S_AG;
      timer    <= '0;
      o_parade <= 1'b0;
    end else begin
      state    <= next_state;
      o_parade <= (next_state == S_BG) && i_M;
      if (next_state != state) timer <= '0;
      else if (!done)          timer <= timer + 1'b1;
    end
  end

  assign lights = decode_lights(state);
  assign o_LA   = lights.la;
  assign o_LB   = lights.lb;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: table-driven normal cycle plus hand-written
// sequences for sensor latency, parade, reset-in-yellow and the 1/1 timing corner.
module tb_traffic_light_ctrl;

  localparam logic [1:0] G = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] R = 2'b10;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       m = 1'b0, ta = 1'b0, tb = 1'b0;
  logic [1:0] la, lb, la2, lb2;
  logic       par, par2;

  always #5 clk = ~clk;

  traffic_light_ctrl #(.MIN_GREEN(4), .YELLOW_LEN(2)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_M(m), .i_TA(ta), .i_TB(tb),
    .o_LA(la), .o_LB(lb), .o_parade(par)
  );

  traffic_light_ctrl #(.MIN_GREEN(1), .YELLOW_LEN(1)) dut_min (
    .i_clk(clk), .i_rstn(rstn), .i_M(m), .i_TA(ta), .i_TB(tb),
    .o_LA(la2), .o_LB(lb2), .o_parade(par2)
  );

  typedef struct {
    logic       ta, tb, m;
    logic [1:0] la, lb;
    logic       par;
  } vec_t;

  typedef struct {
    logic [4:0] exp;
    bit         sel;
    string      name;
  } sb_t;

  sb_t  sbq[$];
  vec_t vecs[24];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check_now(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {la,lb,par}=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge: drive, expect after next rising edge, return at next falling edge.
  task automatic step(input logic ita, itb, im, input logic [1:0] ela, elb,
                      input logic epar, input bit sel, input string name);
    sb_t e;
    ta = ita; tb = itb; m = im;
    e.exp = {ela, elb, epar}; e.sel = sel; e.name = name;
    sbq.push_back(e);
    @(posedge clk); #1;
    if (sbq.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sbq.pop_front();
      check_now(e.name, e.sel ? {la2, lb2, par2} : {la, lb, par}, e.exp);
    end
    @(negedge clk);
  endtask

  // Asserts reset mid low-phase, checks outputs before any edge, releases at next falling edge.
  task automatic do_reset(input logic ita, itb, im, input string name);
    #1 rstn = 1'b0;
    #1;
    check_now({name, "_main"}, {la, lb, par}, {G, R, 1'b0});
    check_now({name, "_min"}, {la2, lb2, par2}, {G, R, 1'b0});
    ta = ita; tb = itb; m = im;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    // Normal cycle table: edge k after release, pattern AY at k=4 repeating every 12.
    for (int k = 1; k <= 24; k++) begin
      int pos;
      pos = (k + 8) % 12;
      vecs[k-1] = '{ta: 1'b0, tb: 1'b0, m: 1'b0, la: G, lb: R, par: 1'b0};
      if (pos < 2)      begin vecs[k-1].la = Y; vecs[k-1].lb = R; end
      else if (pos < 6) begin vecs[k-1].la = R; vecs[k-1].lb = G; end
      else if (pos < 8) begin vecs[k-1].la = R; vecs[k-1].lb = Y; end
    end

    @(negedge clk);

    // Reset with A traffic held: stays A green.
    do_reset(1'b1, 1'b0, 1'b0, "reset_ta");
    for (int i = 0; i < 20; i++) step(1, 0, 0, G, R, 0, 0, "ta_hold");

    // Sensor latency: A traffic drops just after an edge, yellow appears 3 edges later.
    step(0, 0, 0, G, R, 0, 0, "lat_n1");
    step(0, 0, 0, G, R, 0, 0, "lat_n2");
    step(0, 0, 0, Y, R, 0, 0, "lat_n3");

    // Normal free-running cycle.
    do_reset(1'b0, 1'b0, 1'b0, "reset_norm");
    for (int i = 0; i < 24; i++)
      step(vecs[i].ta, vecs[i].tb, vecs[i].m, vecs[i].la, vecs[i].lb, vecs[i].par, 0, "normal");

    // Reset in A yellow with timer=1, then a full green again.
    do_reset(1'b0, 1'b0, 1'b0, "reset_pre_ay");
    for (int i = 0; i < 3; i++) step(0, 0, 0, G, R, 0, 0, "ay_ag");
    step(0, 0, 0, Y, R, 0, 0, "ay_t0");
    step(0, 0, 0, Y, R, 0, 0, "ay_t1");
    do_reset(1'b0, 1'b0, 1'b0, "reset_mid_ay");
    for (int i = 0; i < 3; i++) step(0, 0, 0, G, R, 0, 0, "post_rst_ag");
    step(0, 0, 0, Y, R, 0, 0, "post_rst_ay");

    // Same corner with MIN_GREEN=1, YELLOW_LEN=1.
    do_reset(1'b0, 1'b0, 1'b0, "reset_min");
    step(0, 0, 0, Y, R, 0, 1, "min_ay");
    step(0, 0, 0, R, G, 0, 1, "min_bg");
    step(0, 0, 0, R, Y, 0, 1, "min_by");
    step(0, 0, 0, G, R, 0, 1, "min_ag");
    step(0, 0, 0, Y, R, 0, 1, "min_ay2");
    do_reset(1'b0, 1'b0, 1'b0, "reset_min_ay");
    step(0, 0, 0, Y, R, 0, 1, "min_post_rst");

    // Parade: M set in A green, B green held with parade flag, release to yellow next cycle.
    do_reset(1'b0, 1'b0, 1'b1, "reset_par");
    for (int i = 0; i < 3; i++) step(0, 0, 1, G, R, 0, 0, "par_ag");
    step(0, 0, 1, Y, R, 0, 0, "par_ay");
    step(0, 0, 1, Y, R, 0, 0, "par_ay");
    for (int i = 0; i < 50; i++) step(0, 0, 1, R, G, 1, 0, "par_hold");
    step(0, 0, 0, R, Y, 0, 0, "par_rel_by");
    step(0, 0, 0, R, Y, 0, 0, "par_rel_by2");
    step(0, 0, 0, G, R, 0, 0, "par_rel_ag");

    // M rises during B yellow with A traffic: A gets exactly MIN_GREEN then yields.
    do_reset(1'b0, 1'b0, 1'b0, "reset_mby");
    for (int i = 0; i < 3; i++) step(0, 0, 0, G, R, 0, 0, "mby_ag");
    step(0, 0, 0, Y, R, 0, 0, "mby_ay");
    step(0, 0, 0, Y, R, 0, 0, "mby_ay");
    step(0, 0, 0, R, G, 0, 0, "mby_bg");
    step(0, 0, 0, R, G, 0, 0, "mby_bg");
    step(1, 0, 0, R, G, 0, 0, "mby_bg");
    step(1, 0, 0, R, G, 0, 0, "mby_bg");
    step(1, 0, 0, R, Y, 0, 0, "mby_by0");
    step(1, 0, 1, R, Y, 0, 0, "mby_by1");
    for (int i = 0; i < 4; i++) step(1, 0, 1, G, R, 0, 0, "mby_ag4");
    step(1, 0, 1, Y, R, 0, 0, "mby_ay_exit");
    step(1, 0, 1, Y, R, 0, 0, "mby_ay2");
    step(1, 0, 1, R, G, 1, 0, "mby_bg_par");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
